cle_key_reader: RTL and testbench



---
 rtl/cle_key_pkg.sv | 35 +++
 rtl/cle_key_shift.sv | 39 +++
 rtl/cle_key_reader.sv | 176 +++++++++++++++++
 tb/tb_cle_key_reader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cle_key_pkg.sv
// cle_key_pkg
// Shared types and constants for the CLE04A key reader and its helpers.
//   state_t     : reader FSM states
//   phase_t     : which half of the sequence an access belongs to
//   UNLOCK_TBL  : BA7..BA4 nibbles replayed during the unlock phase, entry 0 first
//   BA13_SEL/BA12_SEL : address bits that place an access in the responder window
//   unlock_nib  : table lookup that returns 0 for entries past the table end
package cle_key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    GAP,
    DONE
  } state_t;

  typedef enum logic {
    UNLOCK,
    READ
  } phase_t;

  // Element 0 is the rightmost nibble, so the replay order is 2, A, E, 9.
  localparam logic [7:0][3:0] UNLOCK_TBL = {
    4'h0, 4'h0, 4'h0, 4'h0, 4'h9, 4'hE, 4'hA, 4'h2
  };

  localparam logic BA13_SEL = 1'b0;
  localparam logic BA12_SEL = 1'b1;

  function automatic logic [3:0] unlock_nib(input logic [4:0] idx);
    unlock_nib = (idx < 5'd8) ? UNLOCK_TBL[idx[2:0]] : 4'h0;
  endfunction

endpackage

// File: rtl/cle_key_shift.sv
// cle_key_shift
// MSB-first serial-in shift register used to assemble the key word.
//   clk      : clock, rising edge
//   clear    : synchronous clear, wins over shift_en
//   shift_en : shift sdin in at the LSB end on this edge
//   sdin     : serial input bit
//   q        : register contents; the first bit shifted in ends up at the MSB
module cle_key_shift #(
  parameter int KEY_BITS = 16
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                shift_en,
  input  logic                sdin,
  output logic [KEY_BITS-1:0] q
);

  // A one-bit key has no upper slice to carry along, so it gets its own branch.
  generate
    if (KEY_BITS == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (clear) begin
          q <= '0;
        end else if (shift_en) begin
          q <= sdin;
        end
      end
    end else begin : g_wide
      always_ff @(posedge clk) begin
        if (clear) begin
          q <= '0;
        end else if (shift_en) begin
          q <= {q[KEY_BITS-2:0], sdin};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cle_key_reader.sv
// cle_key_reader
// Host-side initiator for the CLE04A serial key responder. On start it replays
// the unlock accesses, then performs KEY_BITS read accesses and collects SDRD
// into key_data (first bit read lands in the MSB).
//   clk, rst         : clock and synchronous active-high reset
//   start, abort     : controller requests
//   busy, done       : sequence in progress / one-cycle completion pulse
//   key_valid        : a full key has been read since the last start
//   key_data         : assembled key
//   sser_n, ba13, ba12, ba7_4, br_w : registered backplane access lines
//   sdrd             : serial data from the responder
module cle_key_reader
  import cle_key_pkg::*;
#(
  parameter int          KEY_BITS   = 16,
  parameter int          UNLOCK_LEN = 4,
  parameter int          GAP_CYC    = 2,
  parameter logic [3:0]  READ_NIB   = 4'h2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                key_valid,
  output logic [KEY_BITS-1:0] key_data,
  output logic                sser_n,
  output logic                ba13,
  output logic                ba12,
  output logic [3:0]          ba7_4,
  output logic                br_w,
  input  logic                sdrd
);

  state_t     state;
  phase_t     phase;
  logic [4:0] acc_cnt;
  logic [3:0] gap_cnt;

  logic [4:0] acc_inc;
  logic       last_unlock;
  logic       last_read;
  logic       access_end;
  logic       abort_now;
  logic       shift_en;
  logic [3:0] next_nib;

  // Decode of where the current access stands. access_end marks the last
  // cycle of an access: the STROBE itself when there is no gap, otherwise the
  // final GAP cycle.
  assign acc_inc     = acc_cnt + 5'd1;
  assign last_unlock = (phase == UNLOCK) && (acc_cnt == 5'(UNLOCK_LEN - 1));
  assign last_read   = (phase == READ) && (acc_cnt == 5'(KEY_BITS - 1));
  assign access_end  = (GAP_CYC == 0) ? (state == STROBE)
                                      : ((state == GAP) && (gap_cnt == 4'(GAP_CYC - 1)));
  assign abort_now   = abort && ((state == SETUP) || (state == STROBE) || (state == GAP));
  assign shift_en    = (state == STROBE) && (phase == READ);
  assign next_nib    = ((phase == READ) || last_unlock) ? READ_NIB : unlock_nib(acc_inc);

  // Key capture happens on the closing edge of every read-phase strobe, even
  // when an abort ends the sequence there, so the responder's bit is never lost.
  cle_key_shift #(
    .KEY_BITS (KEY_BITS)
  ) u_shift (
    .clk      (clk),
    .clear    (rst),
    .shift_en (shift_en),
    .sdin     (sdrd),
    .q        (key_data)
  );

  // Main sequencer. Abort has top priority because it can only land in
  // SETUP, STROBE or GAP, and in STROBE it only cuts the sequence after the
  // strobe edge. The access-end branch handles both the "next access" and
  // "sequence finished" transitions so they look the same with or without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= UNLOCK;
      acc_cnt   <= '0;
      gap_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      sser_n    <= 1'b1;
      ba13      <= 1'b1;
      ba12      <= 1'b0;
      ba7_4     <= 4'h0;
      br_w      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_now) begin
        state  <= DONE;
        busy   <= 1'b0;
        done   <= 1'b1;
        sser_n <= 1'b1;
        ba13   <= 1'b1;
        ba12   <= 1'b0;
        br_w   <= 1'b0;
        ba7_4  <= 4'h0;
      end else if (access_end) begin
        if (last_read) begin
          state     <= DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          key_valid <= 1'b1;
          sser_n    <= 1'b1;
          ba13      <= 1'b1;
          ba12      <= 1'b0;
          br_w      <= 1'b0;
          ba7_4     <= 4'h0;
        end else begin
          state  <= SETUP;
          sser_n <= 1'b1;
          ba13   <= BA13_SEL;
          ba12   <= BA12_SEL;
          br_w   <= 1'b1;
          ba7_4  <= next_nib;
          if (last_unlock) begin
            phase   <= READ;
            acc_cnt <= '0;
          end else begin
            acc_cnt <= acc_inc;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= SETUP;
              phase     <= UNLOCK;
              acc_cnt   <= '0;
              gap_cnt   <= '0;
              busy      <= 1'b1;
              key_valid <= 1'b0;
              sser_n    <= 1'b1;
              ba13      <= BA13_SEL;
              ba12      <= BA12_SEL;
              br_w      <= 1'b1;
              ba7_4     <= unlock_nib(5'd0);
            end else if (abort) begin
              key_valid <= 1'b0;
            end
          end
          SETUP: begin
            state  <= STROBE;
            sser_n <= 1'b0;
          end
          STROBE: begin
            state   <= GAP;
            gap_cnt <= '0;
            sser_n  <= 1'b1;
            ba13    <= 1'b1;
            ba12    <= 1'b0;
            br_w    <= 1'b0;
            ba7_4   <= 4'h0;
          end
          GAP: begin
            gap_cnt <= gap_cnt + 4'd1;
          end
          DONE: begin
            state   <= IDLE;
            phase   <= UNLOCK;
            acc_cnt <= '0;
            gap_cnt <= '0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cle_key_reader.sv
// tb_cle_key_reader
// Bench for cle_key_reader. A behavioural CLE04A responder (built around
// cle_key_shift) watches the default-parameter reader's bus, tracks the unlock
// sequence and returns a preloaded key MSB first. Expected strobe nibbles are
// queued when a sequence is started and consumed by a bus monitor. A second
// reader with the smallest parameters covers the gap-free timing.
`timescale 1ns/1ps
module tb_cle_key_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort;
  logic        busy, done, key_valid;
  logic [15:0] key_data;
  logic        sser_n, ba13, ba12, br_w, sdrd;
  logic [3:0]  ba7_4;

  logic        s_start, s_abort, s_sdrd;
  logic        s_busy, s_done, s_key_valid;
  logic [0:0]  s_key_data;
  logic        s_sser_n, s_ba13, s_ba12, s_br_w;
  logic [3:0]  s_ba7_4;

  int checks = 0;
  int errors = 0;

  cle_key_reader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .key_valid(key_valid), .key_data(key_data),
    .sser_n(sser_n), .ba13(ba13), .ba12(ba12), .ba7_4(ba7_4), .br_w(br_w),
    .sdrd(sdrd)
  );

  cle_key_reader #(
    .KEY_BITS(1), .UNLOCK_LEN(1), .GAP_CYC(0), .READ_NIB(4'h2)
  ) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .busy(s_busy), .done(s_done), .key_valid(s_key_valid), .key_data(s_key_data),
    .sser_n(s_sser_n), .ba13(s_ba13), .ba12(s_ba12), .ba7_4(s_ba7_4), .br_w(s_br_w),
    .sdrd(s_sdrd)
  );

  localparam logic [3:0] EXP_UNLOCK [4] = '{4'h2, 4'hA, 4'hE, 4'h9};

  // Responder model: unlocks after seeing 2,A,E,9 in the window, then shifts
  // its key out on every read strobe (rotating so the key survives).
  logic        rsp_clr, pl_mode, pl_shift, pl_din;
  logic [15:0] rsp_q;
  logic        rsp_unlocked;
  logic [1:0]  rsp_ucnt;
  logic        win_strobe, rd_strobe;

  assign win_strobe = (sser_n == 1'b0) && (ba13 == 1'b0) && (ba12 == 1'b1) && (br_w == 1'b1);
  assign rd_strobe  = win_strobe && rsp_unlocked && (ba7_4 == 4'h2);
  assign sdrd       = rsp_q[15];

  cle_key_shift #(.KEY_BITS(16)) u_rsp (
    .clk(clk), .clear(rsp_clr),
    .shift_en(pl_mode ? pl_shift : rd_strobe),
    .sdin(pl_mode ? pl_din : rsp_q[15]),
    .q(rsp_q)
  );

  // Unlock tracker of the responder model.
  always @(posedge clk) begin
    if (rsp_clr) begin
      rsp_unlocked <= 1'b0;
      rsp_ucnt     <= 2'd0;
    end else if (win_strobe && !rsp_unlocked) begin
      if (ba7_4 == EXP_UNLOCK[rsp_ucnt]) begin
        if (rsp_ucnt == 2'd3) rsp_unlocked <= 1'b1;
        rsp_ucnt <= rsp_ucnt + 2'd1;
      end else begin
        rsp_ucnt <= 2'd0;
      end
    end
  end

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", what, act, req);
    end
  endtask

  // Bus monitor: every strobe must be a single cycle inside the decode window
  // and carry the next queued nibble.
  logic [3:0] exp_q[$];
  logic [3:0] mon_nib;
  int         strobe_cnt = 0;
  int         done_cnt   = 0;
  logic       prev_low   = 1'b0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (sser_n === 1'b0) begin
      strobe_cnt++;
      checkOutput("sser_n back-to-back low", {31'd0, prev_low}, 0);
      checkOutput("strobe ba13/ba12/br_w", {ba13, ba12, br_w}, 3'b011);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected strobe: nibble %0h, required no strobe", ba7_4);
      end else begin
        mon_nib = exp_q.pop_front();
        checkOutput("strobe nibble", ba7_4, mon_nib);
      end
    end
    prev_low = (sser_n === 1'b0);
  end

  typedef struct {
    string       name;
    logic [15:0] key;
    int          abort_bit;
    int          exp_lat;
    logic        exp_valid;
    int          poke_cyc;
    logic        poke_done;
  } vec_t;

  logic [15:0] exp_key;

  // Loads the responder, queues the expected strobes, starts a sequence and
  // waits (bounded) for done. Cycle 1 is the cycle start is sampled in.
  task automatic applyStimulus(input vec_t v, input int nstr, output int lat,
                               output logic [3:0] snap, output logic [15:0] snap_key);
    int seen;
    @(negedge clk);
    rsp_clr = 1'b1;
    pl_mode = 1'b1;
    @(negedge clk);
    rsp_clr = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      pl_din   = v.key[i];
      pl_shift = 1'b1;
      @(negedge clk);
    end
    pl_shift = 1'b0;
    pl_mode  = 1'b0;
    for (int i = 0; i < nstr; i++) exp_q.push_back((i < 4) ? EXP_UNLOCK[i] : 4'h2);
    start    = 1'b1;
    seen     = 0;
    lat      = 0;
    snap     = '0;
    snap_key = '0;
    for (int cyc = 2; cyc <= 150 && lat == 0; cyc++) begin
      @(negedge clk);
      start = (cyc == v.poke_cyc);
      abort = 1'b0;
      if (cyc == 2) checkOutput({v.name, " busy after start"}, {31'd0, busy}, 1);
      if (done === 1'b1) begin
        lat      = cyc;
        snap     = {done, busy, sser_n, key_valid};
        snap_key = key_data;
        start    = v.poke_done;
      end else if (sser_n === 1'b0) begin
        seen++;
        if (v.abort_bit >= 0 && seen == 5 + v.abort_bit) abort = 1'b1;
      end
    end
    if (start) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b0;
    if (lat == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: no done within 150 cycles", v.name);
    end
  endtask

  task automatic runVector(input vec_t v);
    int          lat, s0, d0, nstr;
    logic [3:0]  snap;
    logic [15:0] snap_key;
    nstr = (v.abort_bit < 0) ? 20 : 5 + v.abort_bit;
    s0   = strobe_cnt;
    d0   = done_cnt;
    applyStimulus(v, nstr, lat, snap, snap_key);
    if (v.abort_bit < 0) begin
      exp_key = v.key;
    end else begin
      for (int i = 0; i <= v.abort_bit; i++) exp_key = {exp_key[14:0], v.key[15-i]};
    end
    checkOutput({v.name, " latency"}, lat, v.exp_lat);
    checkOutput({v.name, " done/busy/sser_n/key_valid"}, snap, {3'b101, v.exp_valid});
    checkOutput({v.name, " key_data"}, snap_key, exp_key);
    repeat (30) @(negedge clk);
    checkOutput({v.name, " strobe count"}, strobe_cnt - s0, nstr);
    checkOutput({v.name, " done pulses"}, done_cnt - d0, 1);
    checkOutput({v.name, " strobes left"}, exp_q.size(), 0);
    checkOutput({v.name, " key_valid held"}, {31'd0, key_valid}, {31'd0, v.exp_valid});
    checkOutput({v.name, " busy idle"}, {31'd0, busy}, 0);
    exp_q.delete();
  endtask

  vec_t vecs[4];
  vec_t post_rst;
  int   s_lat;

  initial begin
    vecs[0]  = '{"full A5C3",     16'hA5C3, -1, 82, 1'b1, 0,  1'b0};
    vecs[1]  = '{"abort bit5",    16'h0FF0,  5, 40, 1'b0, 0,  1'b0};
    vecs[2]  = '{"full 3C5A",     16'h3C5A, -1, 82, 1'b1, 0,  1'b0};
    vecs[3]  = '{"start ignored", 16'h1234, -1, 82, 1'b1, 10, 1'b1};
    post_rst = '{"post-rst A5C3", 16'hA5C3, -1, 82, 1'b1, 0,  1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    s_start = 1'b0; s_abort = 1'b0; s_sdrd = 1'b1;
    rsp_clr = 1'b1; pl_mode = 1'b1; pl_shift = 1'b0; pl_din = 1'b0;
    exp_key = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset outputs", {busy, done, key_valid, sser_n, ba13, ba12, br_w, ba7_4}, 11'b000_1100_0000);
    checkOutput("reset key_data", key_data, 0);
    checkOutput("small reset outputs", {s_busy, s_done, s_key_valid, s_sser_n, s_ba13, s_ba12, s_br_w, s_ba7_4}, 11'b000_1100_0000);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) runVector(vecs[t]);

    // Smallest configuration: no gap, one unlock access, one key bit.
    $display("[TB] small configuration run");
    @(negedge clk);
    s_start = 1'b1;
    s_lat   = 0;
    for (int cyc = 2; cyc <= 20 && s_lat == 0; cyc++) begin
      @(negedge clk);
      s_start = 1'b0;
      if (s_done === 1'b1) begin
        s_lat = cyc;
      end else begin
        if (cyc <= 5) checkOutput("small sser_n pattern", {31'd0, s_sser_n}, (cyc % 2 == 1) ? 0 : 1);
        if (s_sser_n === 1'b0) checkOutput("small strobe nibble", s_ba7_4, 4'h2);
      end
    end
    checkOutput("small latency", s_lat, 6);
    checkOutput("small key_data", {31'd0, s_key_data}, 1);
    checkOutput("small key_valid/busy", {s_key_valid, s_busy}, 2'b10);

    // Reset while sitting in the gap after the second unlock access.
    $display("[TB] mid-sequence reset");
    @(negedge clk);
    for (int i = 0; i < 20; i++) exp_q.push_back((i < 4) ? EXP_UNLOCK[i] : 4'h2);
    start = 1'b1;
    for (int cyc = 2; cyc <= 8; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("gap bus idle", {sser_n, ba13, ba12, br_w, ba7_4}, 8'b1100_0000);
    checkOutput("busy in gap", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-run rst outputs", {busy, done, key_valid, sser_n, ba13, ba12, br_w, ba7_4}, 11'b000_1100_0000);
    checkOutput("mid-run rst key_data", key_data, 0);
    rst = 1'b0;
    exp_q.delete();
    exp_key = '0;
    runVector(post_rst);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
